// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates an instruction-fetch port and a data port onto one single-ported
// memory. Each request is translated from a byte address to a word index
// relative to its port's base address, checked for range/alignment/select
// faults, issued to memory for one ACCESS cycle, then waits MEM_LAT cycles
// for read data before pulsing the granted port's ready.
//
// Ports:
//   clk_in, reset            clock, asynchronous active-low reset
//   i_req/i_addr             fetch request and byte address
//   i_rdata/i_ready          fetched word (held) and completion pulse
//   d_req/d_we/d_sel/d_addr  data request, store flag, size select, address
//   d_wdata                  store data
//   d_rdata/d_ready          load data (held) and completion pulse
//   err                      fault flag, valid alongside either ready
//   busy                     FSM not idle
//   mem_*                    memory strobe, write enable, select, word index,
//                            write data and read data
module mem_port_arbiter #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_AW  = 11,
    parameter logic [31:0] IBASE   = 32'h0040_0000,
    parameter logic [31:0] DBASE   = 32'h1001_0000,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_sel,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              err,
    output logic              busy,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [2:0]        mem_sel,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_data_q, last_data_d;  // 1 = data port won last grant
    logic              gnt_data_q, gnt_data_d;
    logic              we_q, we_d;
    logic [2:0]        sel_q, sel_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              fault_q, fault_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic        any_req, pick_data, sel_bad, align_bad, req_fault;
    logic [31:0] req_addr, req_base, req_off;
    logic [2:0]  req_sel;

    // Grant selection and fault decode for the request that would win now.
    always_comb begin
        any_req   = i_req | d_req;
        // On a tie the port that did not win last time goes next.
        pick_data = d_req & (~i_req | ~last_data_q);
        req_addr  = pick_data ? d_addr : i_addr;
        req_base  = pick_data ? DBASE : IBASE;
        req_sel   = pick_data ? d_sel : 3'b000;
        req_off   = req_addr - req_base;
        sel_bad   = req_sel > 3'b010;
        align_bad = ((req_sel == 3'b000) && (req_addr[1:0] != 2'b00)) ||
                    ((req_sel == 3'b001) && req_addr[0]);
        // Word index beyond DEPTH shows up as any set bit above the index field.
        req_fault = (req_addr < req_base) || ((req_off >> (MEM_AW + 2)) != 32'd0) ||
                    align_bad || sel_bad;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_data_d = last_data_q;
        gnt_data_d  = gnt_data_q;
        we_d        = we_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        fault_d     = fault_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d     = req_fault ? StResp : StAccess;
                    last_data_d = pick_data;
                    gnt_data_d  = pick_data;
                    we_d        = pick_data & d_we;
                    sel_d       = req_sel;
                    addr_d      = req_off[MEM_AW+1:2];
                    wdata_d     = pick_data ? d_wdata : '0;
                    fault_d     = req_fault;
                    // A faulting response returns zero on the granted port.
                    if (req_fault) begin
                        if (pick_data) d_rdata_d = '0;
                        else           i_rdata_d = '0;
                    end
                end
            end
            StAccess: begin
                state_d = StWait;
                cnt_d   = 4'(MEM_LAT - 1);
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    if (gnt_data_q) d_rdata_d = we_q ? '0 : mem_rdata;
                    else            i_rdata_d = mem_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            last_data_q <= 1'b1;
            gnt_data_q  <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            fault_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_data_q <= last_data_d;
            gnt_data_q  <= gnt_data_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            fault_q     <= fault_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Outputs decode straight from state so reset clears them without a clock.
    always_comb begin
        busy      = state_q != StIdle;
        mem_cs    = state_q == StAccess;
        mem_we    = mem_cs & we_q;
        mem_sel   = mem_cs ? sel_q : 3'b000;
        mem_addr  = mem_cs ? addr_q : '0;
        mem_wdata = mem_cs ? wdata_q : '0;
        i_ready   = (state_q == StResp) & ~gnt_data_q;
        d_ready   = (state_q == StResp) & gnt_data_q;
        err       = (state_q == StResp) & fault_q;
        i_rdata   = i_rdata_q;
        d_rdata   = d_rdata_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory and an
// expected-response queue; also builds MEM_LAT = 1 and MEM_LAT = 8 instances.
module tb_mem_port_arbiter;
    localparam int          LAT = 2;
    localparam logic [31:0] IB  = 32'h0040_0000;
    localparam logic [31:0] DB  = 32'h1001_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [2:0]  d_sel;
    logic [31:0] i_rdata, d_rdata, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        i_ready, d_ready, err, busy, mem_cs, mem_we;
    logic [2:0]  mem_sel;
    logic [10:0] mem_addr;

    mem_port_arbiter dut (
        .clk_in(clk), .reset(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .err(err), .busy(busy),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Latency-variant builds share one fetch stimulus and a constant memory.
    logic        lq_req;
    logic [31:0] lq_addr;
    logic [31:0] l1_ird, l1_drd, l1_mwd, l8_ird, l8_drd, l8_mwd;
    logic        l1_ir, l1_dr, l1_err, l1_busy, l1_cs, l1_we;
    logic        l8_ir, l8_dr, l8_err, l8_busy, l8_cs, l8_we;
    logic [2:0]  l1_sel, l8_sel;
    logic [10:0] l1_ma, l8_ma;

    mem_port_arbiter #(.MEM_LAT(1)) dut_l1 (
        .clk_in(clk), .reset(rst_n),
        .i_req(lq_req), .i_addr(lq_addr), .i_rdata(l1_ird), .i_ready(l1_ir),
        .d_req(1'b0), .d_we(1'b0), .d_sel(3'b000), .d_addr(32'h0), .d_wdata(32'h0),
        .d_rdata(l1_drd), .d_ready(l1_dr), .err(l1_err), .busy(l1_busy),
        .mem_cs(l1_cs), .mem_we(l1_we), .mem_sel(l1_sel), .mem_addr(l1_ma),
        .mem_wdata(l1_mwd), .mem_rdata(32'hCAFE_F00D)
    );

    mem_port_arbiter #(.MEM_LAT(8)) dut_l8 (
        .clk_in(clk), .reset(rst_n),
        .i_req(lq_req), .i_addr(lq_addr), .i_rdata(l8_ird), .i_ready(l8_ir),
        .d_req(1'b0), .d_we(1'b0), .d_sel(3'b000), .d_addr(32'h0), .d_wdata(32'h0),
        .d_rdata(l8_drd), .d_ready(l8_dr), .err(l8_err), .busy(l8_busy),
        .mem_cs(l8_cs), .mem_we(l8_we), .mem_sel(l8_sel), .mem_addr(l8_ma),
        .mem_wdata(l8_mwd), .mem_rdata(32'hCAFE_F00D)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory: unwritten words read as a per-index pattern.
    logic [31:0] mem [int];
    function automatic logic [31:0] pat(input int idx);
        return 32'h5A5A_0000 | 32'(idx);
    endfunction
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) mem[int'(mem_addr)] = mem_wdata;
            else mem_rdata <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)]
                                                         : pat(int'(mem_addr));
        end
    end

    // Record each memory strobe.
    int          cs_cnt = 0;
    int          cs_cyc = 0;
    logic [10:0] m_addr;
    logic        m_we;
    logic [2:0]  m_sel;
    logic [31:0] m_wdata;
    always @(negedge clk) begin
        if (mem_cs) begin
            cs_cnt  <= cs_cnt + 1;
            cs_cyc  <= cyc;
            m_addr  <= mem_addr;
            m_we    <= mem_we;
            m_sel   <= mem_sel;
            m_wdata <= mem_wdata;
        end
    end

    typedef struct {
        logic        is_data;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    int total = 0;
    int bad = 0;
    int t_issue = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request, queue its expected response, then wait for a ready.
    task automatic txn(input string tag, input logic is_data, input logic we,
                       input logic [2:0] sel, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic exp_err,
                       input logic [31:0] exp_rd);
        exp_t e;
        int   t0;
        int   cs0;
        bit   seen;
        @(negedge clk);
        if (is_data) begin
            d_req = 1'b1; d_we = we; d_sel = sel; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        sbq.push_back('{is_data, exp_err, exp_rd, exp_err ? 1 : LAT + 2});
        t0 = cyc;
        cs0 = cs_cnt;
        t_issue = t0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (i_ready || d_ready) seen = 1'b1;
        end
        e = sbq.pop_front();
        check({tag, "_ready_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_port"}, 32'({i_ready, d_ready}), e.is_data ? 32'd1 : 32'd2);
            check({tag, "_err"}, 32'(err), 32'(e.err));
            check({tag, "_rdata"}, e.is_data ? d_rdata : i_rdata, e.rdata);
            check({tag, "_lat"}, 32'(cyc - t0), 32'(e.lat));
            check({tag, "_cs_cnt"}, 32'(cs_cnt - cs0), e.err ? 32'd0 : 32'd1);
        end
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        int   t0;
        int   lat1;
        int   lat8;
        i_req = 0; d_req = 0; d_we = 0; d_sel = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0;
        lq_req = 0; lq_addr = 0;
        #1 rst_n = 1'b0;
        #11;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_cs", 32'(mem_cs), 32'd0);
        check("rst_i_ready", 32'(i_ready), 32'd0);
        check("rst_d_ready", 32'(d_ready), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Store: one strobe with we, index 1, store data, zero rdata.
        txn("st", 1, 1, 3'b000, DB + 32'd4, 32'h1234_5678, 0, 32'h0);
        check("st_mem_we", 32'(m_we), 32'd1);
        check("st_mem_addr", 32'(m_addr), 32'd1);
        check("st_mem_wdata", m_wdata, 32'h1234_5678);
        check("st_mem_content", mem[1], 32'h1234_5678);

        // Seed index 2 through the data port, then fetch it.
        txn("st2", 1, 1, 3'b000, DB + 32'd8, 32'hDEAD_BEEF, 0, 32'h0);
        txn("fetch", 0, 0, 3'b000, IB + 32'd8, 32'h0, 0, 32'hDEAD_BEEF);
        check("fetch_mem_addr", 32'(m_addr), 32'd2);
        check("fetch_cs_cycle", 32'(cs_cyc - t_issue), 32'd1);
        check("fetch_mem_sel", 32'(m_sel), 32'd0);

        txn("ld", 1, 0, 3'b000, DB + 32'd4, 32'h0, 0, 32'h1234_5678);
        check("fetch_hold", i_rdata, 32'hDEAD_BEEF);
        txn("ld_half", 1, 0, 3'b001, DB + 32'd2, 32'h0, 0, pat(0));
        check("ld_half_sel", 32'(m_sel), 32'd1);
        check("ld_half_addr", 32'(m_addr), 32'd0);
        txn("ld_byte", 1, 0, 3'b010, DB + 32'd3, 32'h0, 0, pat(0));
        txn("ld_last", 1, 0, 3'b000, DB + 32'd8188, 32'h0, 0, pat(2047));
        check("ld_last_addr", 32'(m_addr), 32'd2047);

        // Faults.
        txn("f_below", 1, 0, 3'b000, 32'h1000_FFFC, 32'h0, 1, 32'h0);
        txn("f_word_align", 1, 0, 3'b000, DB + 32'd2, 32'h0, 1, 32'h0);
        txn("f_sel", 1, 0, 3'b111, DB, 32'h0, 1, 32'h0);
        txn("f_half_align", 1, 1, 3'b001, DB + 32'd1, 32'h5555_5555, 1, 32'h0);
        txn("f_range", 1, 0, 3'b000, DB + 32'd8192, 32'h0, 1, 32'h0);
        check("fault_i_hold", i_rdata, 32'hDEAD_BEEF);
        txn("f_i_align", 0, 0, 3'b000, IB + 32'd2, 32'h0, 1, 32'h0);
        txn("f_i_below", 0, 0, 3'b000, IB - 32'd4, 32'h0, 1, 32'h0);

        // Tie from reset release: instruction, data, instruction, data.
        @(negedge clk);
        rst_n = 1'b0;
        i_req = 1'b1; i_addr = IB + 32'd16;
        d_req = 1'b1; d_we = 1'b0; d_sel = 3'b000; d_addr = DB + 32'd32;
        @(negedge clk);
        rst_n = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 4; k++) begin
            sbq.push_back('{k[0], 1'b0, k[0] ? pat(8) : pat(4), 0});
        end
        n = 0;
        for (int k = 0; k < 60 && n < 4; k++) begin
            @(negedge clk);
            if (i_ready || d_ready) begin
                e = sbq.pop_front();
                check("tie_overlap", 32'(i_ready & d_ready), 32'd0);
                check("tie_port", 32'(d_ready), 32'(e.is_data));
                check("tie_rdata", e.is_data ? d_rdata : i_rdata, e.rdata);
                if (n == 0) check("tie_first_lat", 32'(cyc - t0), 32'(LAT + 2));
                n++;
            end
        end
        check("tie_count", 32'(n), 32'd4);
        sbq.delete();
        i_req = 1'b0;
        d_req = 1'b0;

        // Asynchronous reset while the fetch sits in WAIT.
        @(negedge clk);
        i_req = 1'b1; i_addr = IB + 32'd4;
        repeat (2) @(negedge clk);
        check("ar_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_mem_cs", 32'(mem_cs), 32'd0);
        check("ar_i_ready", 32'(i_ready), 32'd0);
        check("ar_i_rdata", i_rdata, 32'd0);
        i_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        txn("ar_fetch", 0, 0, 3'b000, IB + 32'd12, 32'h0, 0, pat(3));

        // MEM_LAT = 1 and 8 builds.
        @(negedge clk);
        lq_req = 1'b1; lq_addr = IB;
        t0 = cyc;
        lat1 = -1;
        lat8 = -1;
        for (int k = 0; k < 20 && lat8 < 0; k++) begin
            @(negedge clk);
            if (l1_ir && lat1 < 0) begin
                lat1 = cyc - t0;
                check("lat1_rdata", l1_ird, 32'hCAFE_F00D);
            end
            if (l8_ir) begin
                lat8 = cyc - t0;
                check("lat8_rdata", l8_ird, 32'hCAFE_F00D);
            end
        end
        lq_req = 1'b0;
        check("lat1_cycles", 32'(lat1), 32'd3);
        check("lat8_cycles", 32'(lat8), 32'd10);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- DATA_W, 32, data width.
- MEM_AW, 11, memory word-index width; DEPTH = 2**MEM_AW.
- IBASE, 32'h00400000, instruction-space base address.
- DBASE, 32'h10010000, data-space base address.
- MEM_LAT, 2, memory read latency in cycles (legal 1..8).
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- clk_in, in, 1, single clock, all state on rising edge.
- reset, in, 1, asynchronous, active-low reset.
- i_req, in, 1, instruction fetch request.
- i_addr, in, 32, fetch byte address.
- i_rdata, out, DATA_W, fetched word.
- i_ready, out, 1, one-cycle fetch completion pulse.
- d_req, in, 1, data request.
- d_we, in, 1, 1 = store, 0 = load.
- d_sel, in, 3, 000 = word, 001 = half, 010 = byte; other codes are illegal.
- d_addr, in, 32, data byte address.
- d_wdata, in, DATA_W, store data.
- d_rdata, out, DATA_W, load data.
- d_ready, out, 1, one-cycle data completion pulse.
- err, out, 1, valid with either ready; range, alignment or select fault.
- busy, out, 1, FSM not in IDLE.
- mem_cs, out, 1, memory access strobe.
- mem_we, out, 1, memory write enable.
- mem_sel, out, 3, d_sel passthrough; 000 for fetches.
- mem_addr, out, MEM_AW, word index.
- mem_wdata, out, DATA_W, store data to memory.
- mem_rdata, in, DATA_W, memory read data.

Function
REQ-003 Requester SHALL hold req, addr, we, sel and wdata stable from req assertion until its ready pulse.
REQ-004 FSM SHALL have states IDLE, ACCESS, WAIT, RESP.
REQ-005 IDLE with any req SHALL grant one port and latch its fields at the clock edge; next state is ACCESS, or RESP if the request faults.
REQ-006 Arbitration when only one req is high SHALL grant that port.
REQ-007 Arbitration when both reqs are high SHALL grant the port not granted last; the last-grant flag SHALL reset to data, so the first tie goes to instruction.
REQ-008 Word index SHALL be (addr - base) >> 2, truncated to MEM_AW, with base = IBASE for fetches and DBASE for data.
REQ-009 A request SHALL fault if any of the following holds:
- addr < base;
- (addr - base) >> 2 >= DEPTH;
- fetch with addr[1:0] != 0;
- word access with addr[1:0] != 0;
- half access with addr[0] != 0;
- d_sel is an illegal code.
REQ-010 A faulting request SHALL not assert mem_cs and SHALL complete with ready = 1, err = 1, rdata = 0 one cycle after grant.
REQ-011 ACCESS SHALL last exactly one cycle and drive mem_cs = 1 with the latched mem_we, mem_sel, mem_addr and mem_wdata; mem_cs SHALL be 0 in every other state.
REQ-012 WAIT SHALL last exactly MEM_LAT cycles, counted by a down-counter; mem_rdata SHALL be captured at the end of the last WAIT cycle.
REQ-013 RESP SHALL last one cycle and pulse the granted port's ready with err = 0.
- Loads and fetches present the captured word on rdata.
- Stores present rdata = 0.
- The other port's ready stays 0.
REQ-014 Latency SHALL be: req sampled in cycle 0, ready in cycle MEM_LAT + 2 for non-faulting requests, cycle 1 for faulting requests.
REQ-015 rdata outputs SHALL hold their value until the next ready on the same port.
REQ-016 RESP SHALL return to IDLE; a req still high in IDLE is treated as a new transaction, giving a minimum spacing of MEM_LAT + 3 cycles between back-to-back transactions.
REQ-017 A req that drops before grant SHALL be ignored without side effects.

Reset
REQ-018 reset low SHALL immediately, without a clock, set:
- FSM to IDLE and the WAIT counter to 0;
- last-grant flag to data;
- all outputs to 0.
REQ-019 reset asserted mid-transaction SHALL abort it with no ready pulse; a store aborted in WAIT or RESP has already been written.
REQ-020 After reset deasserts, the first rising edge SHALL sample requests normally.

Verification
REQ-021 Fetch, MEM_LAT = 2: i_req, i_addr = 32'h00400008, mem_rdata = 32'hDEADBEEF -> mem_addr = 2 in cycle 1, i_ready = 1 with i_rdata = 32'hDEADBEEF in cycle 4.
REQ-022 Store: d_we = 1, d_sel = 000, d_addr = 32'h10010004, d_wdata = 32'h12345678 -> one-cycle mem_cs with mem_we = 1, mem_addr = 1, d_ready in cycle 4, d_rdata = 0.
REQ-023 Tie then tie: both reqs held high from reset release -> grant order instruction, data, instruction, data; ready pulses never overlap.
REQ-024 Faults, each in its own transaction:
- d_addr = 32'h1000FFFC;
- d_sel = 000 with d_addr = 32'h10010002;
- d_sel = 111;
- each gives d_ready = err = 1 in cycle 1, no mem_cs.
REQ-025 Async reset in WAIT: reset low mid-fetch -> busy, mem_cs and i_ready drop to 0 before the next edge; a fresh fetch after release completes normally.
REQ-026 MEM_LAT = 1 and MEM_LAT = 8 builds: fetch -> ready in cycles 3 and 10 respectively.
